mac_psum_sequencer: RTL and testbench

// - Producer side of the psum stream consumed by the MAC psum accumulator.
// - Takes untagged fp32 partial sums from the MAC array and re-emits them through a one-stage register slice.
// - Tags each psum with inter_end (last psum of a pass) and accum_end (last psum of the final pass).
// - Pass geometry is latched from config on start; o_done pulses once the whole job has drained downstream.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_psum_reg_slice.sv | 47 ++++
 rtl/mac_psum_sequencer.sv | 124 ++++++++++++
 tb/tb_mac_psum_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC psum path: sequencer FSM states and the tagged psum beat.
package mac_pkg;

   localparam int FP32_W          = 32;
   localparam int PSUM_FIFO_DEPTH = 64;

   typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN} seq_state_e;

   typedef struct packed {
      logic [FP32_W-1:0] data;
      logic              inter_end;
      logic              accum_end;
   } psum_beat_t;

endpackage

// File: rtl/mac_psum_reg_slice.sv
// One-entry valid/ready register slice carrying a tagged psum beat; full throughput
// because a held beat can be replaced in the same cycle it is consumed.
module mac_psum_reg_slice
   import mac_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  psum_beat_t in_beat_i,
   output logic       out_valid_o,
   output psum_beat_t out_beat_o,
   input  logic       out_ready_i
);

   logic       valid_q, valid_d;
   psum_beat_t beat_q, beat_d;
   logic       load;

   assign in_ready_o = ~valid_q | out_ready_i;
   assign load       = in_valid_i & in_ready_o;

   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (load) begin
         valid_d = 1'b1;
         beat_d  = in_beat_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_beat_o  = beat_q;

endmodule

// File: rtl/mac_psum_sequencer.sv
// Tags the MAC array's psum stream with pass/job boundaries for the psum accumulator
// and reports job completion once the final beat has left the output slice.
module mac_psum_sequencer
   import mac_pkg::*;
#(
   parameter int DATA_W   = FP32_W,
   parameter int MAX_LEN  = PSUM_FIFO_DEPTH,
   parameter int MAX_PASS = 256
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              mac_psum_sequencer_i_start,
   input  logic [6:0]        mac_psum_sequencer_i_cfg_len,
   input  logic [8:0]        mac_psum_sequencer_i_cfg_pass,
   output logic              mac_psum_sequencer_o_busy,
   output logic              mac_psum_sequencer_o_done,
   input  logic              mac_psum_sequencer_i_psum_valid,
   input  logic [DATA_W-1:0] mac_psum_sequencer_i_psum_data,
   output logic              mac_psum_sequencer_o_psum_ready,
   output logic              mac_psum_sequencer_o_psum_valid,
   output logic [DATA_W-1:0] mac_psum_sequencer_o_psum_data,
   output logic              mac_psum_sequencer_o_inter_end,
   output logic              mac_psum_sequencer_o_accum_end,
   input  logic              mac_psum_sequencer_i_psum_ready
);

   function automatic logic [6:0] clamp_len(input logic [6:0] v);
      if (v == 7'd0)          return 7'd1;
      if (v > 7'(MAX_LEN))    return 7'(MAX_LEN);
      return v;
   endfunction

   function automatic logic [8:0] clamp_pass(input logic [8:0] v);
      if (v == 9'd0)          return 9'd1;
      if (v > 9'(MAX_PASS))   return 9'(MAX_PASS);
      return v;
   endfunction

   seq_state_e state_q;
   logic [6:0] len_q;
   logic [8:0] pass_q;
   logic [6:0] elem_cnt_q;
   logic [8:0] pass_cnt_q;

   psum_beat_t in_beat, out_beat;
   logic       slice_in_valid, slice_in_ready, slice_out_valid;
   logic       accept, last_elem, last_pass, out_hs;

   assign last_elem = (elem_cnt_q == len_q - 7'd1);
   assign last_pass = (pass_cnt_q == pass_q - 9'd1);

   assign slice_in_valid = mac_psum_sequencer_i_psum_valid & (state_q == SEQ_RUN);
   assign accept         = slice_in_valid & slice_in_ready;
   assign out_hs         = slice_out_valid & mac_psum_sequencer_i_psum_ready;

   always_comb begin
      in_beat           = '0;
      in_beat.data      = mac_psum_sequencer_i_psum_data;
      in_beat.inter_end = last_elem;
      in_beat.accum_end = last_elem & last_pass;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= SEQ_IDLE;
         len_q      <= '0;
         pass_q     <= '0;
         elem_cnt_q <= '0;
         pass_cnt_q <= '0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (mac_psum_sequencer_i_start) begin
                  len_q      <= clamp_len(mac_psum_sequencer_i_cfg_len);
                  pass_q     <= clamp_pass(mac_psum_sequencer_i_cfg_pass);
                  elem_cnt_q <= '0;
                  pass_cnt_q <= '0;
                  state_q    <= SEQ_RUN;
               end
            end
            SEQ_RUN: begin
               if (accept) begin
                  if (last_elem) begin
                     elem_cnt_q <= '0;
                     if (last_pass) begin
                        pass_cnt_q <= '0;
                        state_q    <= SEQ_DRAIN;
                     end else begin
                        pass_cnt_q <= pass_cnt_q + 9'd1;
                     end
                  end else begin
                     elem_cnt_q <= elem_cnt_q + 7'd1;
                  end
               end
            end
            SEQ_DRAIN: begin
               // Only the final beat can be in the slice here, so its handshake ends the job.
               if (out_hs) state_q <= SEQ_IDLE;
            end
            default: state_q <= SEQ_IDLE;
         endcase
      end
   end

   mac_psum_reg_slice u_slice (
      .clk_i       (i_clk),
      .rst_i       (i_reset),
      .in_valid_i  (slice_in_valid),
      .in_ready_o  (slice_in_ready),
      .in_beat_i   (in_beat),
      .out_valid_o (slice_out_valid),
      .out_beat_o  (out_beat),
      .out_ready_i (mac_psum_sequencer_i_psum_ready)
   );

   assign mac_psum_sequencer_o_psum_ready = (state_q == SEQ_RUN) & slice_in_ready;
   assign mac_psum_sequencer_o_psum_valid = slice_out_valid;
   assign mac_psum_sequencer_o_psum_data  = out_beat.data;
   assign mac_psum_sequencer_o_inter_end  = out_beat.inter_end;
   assign mac_psum_sequencer_o_accum_end  = out_beat.accum_end;
   assign mac_psum_sequencer_o_busy       = (state_q != SEQ_IDLE);
   assign mac_psum_sequencer_o_done       = (state_q == SEQ_DRAIN) & out_hs;

endmodule

// File: tb/tb_mac_psum_sequencer.sv
// Directed bench for mac_psum_sequencer: a job-level model checks every output each
// cycle, and literal expectations per scenario pin the model's tagging.
module tb_mac_psum_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  cfg_len = '0;
   logic [8:0]  cfg_pass = '0;
   logic        o_busy, o_done;
   logic        ivalid = 1'b0;
   logic [31:0] idata = '0;
   logic        o_ready, o_valid, o_ie, o_ae;
   logic [31:0] o_data;
   logic        prdy = 1'b1;

   mac_psum_sequencer dut (
      .i_clk                           (clk),
      .i_reset                         (rst),
      .mac_psum_sequencer_i_start      (start),
      .mac_psum_sequencer_i_cfg_len    (cfg_len),
      .mac_psum_sequencer_i_cfg_pass   (cfg_pass),
      .mac_psum_sequencer_o_busy       (o_busy),
      .mac_psum_sequencer_o_done       (o_done),
      .mac_psum_sequencer_i_psum_valid (ivalid),
      .mac_psum_sequencer_i_psum_data  (idata),
      .mac_psum_sequencer_o_psum_ready (o_ready),
      .mac_psum_sequencer_o_psum_valid (o_valid),
      .mac_psum_sequencer_o_psum_data  (o_data),
      .mac_psum_sequencer_o_inter_end  (o_ie),
      .mac_psum_sequencer_o_accum_end  (o_ae),
      .mac_psum_sequencer_i_psum_ready (prdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        ie;
      logic        ae;
   } beat_t;

   beat_t exp_q[$];
   beat_t log_q[$];
   int n_chk = 0, n_pass = 0;
   int done_cnt = 0;
   bit busy_m = 0;
   int L = 1, P = 1, k_acc = 0;
   bit bp_mode = 0;
   int bp_idx = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int clampv(input int v, input int mx);
      if (v == 0) return 1;
      if (v > mx) return mx;
      return v;
   endfunction

   // Downstream ready: steady 1, or the repeating 1-0-0-1 backpressure pattern.
   always @(posedge clk) begin
      #1;
      if (bp_mode) begin
         case (bp_idx % 4)
            0, 3:    prdy = 1'b1;
            default: prdy = 1'b0;
         endcase
         bp_idx++;
      end else begin
         prdy = 1'b1;
      end
   end

   // Job-level model: expected beats are queued at acceptance with tags derived from
   // the beat's position in the job, and retired on output handshake.
   always @(negedge clk) begin
      bit    ev, er, ed, was_busy, run_m;
      beat_t b;
      if (rst) begin
         chk("reset_outputs",
             {o_busy, o_done, o_ready, o_valid, o_ie, o_ae, o_data}, 64'd0);
         exp_q.delete();
         busy_m = 0;
         k_acc  = 0;
      end else begin
         ev    = (exp_q.size() > 0);
         run_m = busy_m && (k_acc < L * P);
         er    = run_m && (!ev || prdy);
         chk("busy", o_busy, busy_m);
         chk("psum_ready", o_ready, er);
         chk("psum_valid", o_valid, ev);
         if (ev) begin
            chk("psum_data", o_data, exp_q[0].d);
            chk("inter_end", o_ie, exp_q[0].ie);
            chk("accum_end", o_ae, exp_q[0].ae);
         end
         ed = ev && prdy && exp_q[0].ae;
         chk("done", o_done, ed);
         if (ev && prdy) begin
            log_q.push_back('{o_data, o_ie, o_ae});
            void'(exp_q.pop_front());
         end
         if (ivalid && er) begin
            b.d  = idata;
            b.ie = ((k_acc % L) == L - 1);
            b.ae = b.ie && ((k_acc / L) == P - 1);
            exp_q.push_back(b);
            k_acc++;
         end
         was_busy = busy_m;
         if (ed) begin
            busy_m = 0;
            done_cnt++;
         end
         if (!was_busy && start) begin
            busy_m = 1;
            L      = clampv(int'(cfg_len), 64);
            P      = clampv(int'(cfg_pass), 256);
            k_acc  = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int len, input int pass);
      cfg_len  = 7'(len);
      cfg_pass = 9'(pass);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic send(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         ivalid = 1'b1;
         idata  = base + 32'(i);
         @(negedge clk);
         while (!o_ready && t < 200) begin
            t++;
            @(negedge clk);
         end
         if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
         tick();
      end
      ivalid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (o_busy && t < 500) begin
         t++;
         tick();
      end
      chk("idle_timeout", o_busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int  d0;
      bit  done_seen;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Basic: 4 x 3, continuous ready
      log_q.delete();
      d0 = done_cnt;
      start_job(4, 3);
      send(12, 32'h3F80_0000);
      wait_idle();
      chk("basic_count", log_q.size(), 12);
      chk("basic_d0", log_q[0].d, 32'h3F80_0000);
      chk("basic_d11", log_q[11].d, 32'h3F80_000B);
      chk("basic_ie2", log_q[2].ie, 0);
      chk("basic_ie3", log_q[3].ie, 1);
      chk("basic_ie7", log_q[7].ie, 1);
      chk("basic_ae7", log_q[7].ae, 0);
      chk("basic_ie11", log_q[11].ie, 1);
      chk("basic_ae11", log_q[11].ae, 1);
      chk("basic_done", done_cnt - d0, 1);
      tick();

      // Backpressure: 2 x 2 with 1-0-0-1 ready
      log_q.delete();
      bp_mode = 1;
      start_job(2, 2);
      send(4, 32'h4000_0000);
      wait_idle();
      bp_mode = 0;
      tick();
      chk("bp_count", log_q.size(), 4);
      chk("bp_d2", log_q[2].d, 32'h4000_0002);
      chk("bp_ie1", log_q[1].ie, 1);
      chk("bp_ae1", log_q[1].ae, 0);
      chk("bp_ie2", log_q[2].ie, 0);
      chk("bp_ae3", log_q[3].ae, 1);

      // Degenerate: len=0, pass=0
      log_q.delete();
      start_job(0, 0);
      send(1, 32'hC000_0000);
      wait_idle();
      ivalid = 1'b1;
      idata  = 32'hDEAD_BEEF;
      tick();
      tick();
      ivalid = 1'b0;
      chk("degen_count", log_q.size(), 1);
      chk("degen_ie", log_q[0].ie, 1);
      chk("degen_ae", log_q[0].ae, 1);

      // Clamp: len=100 -> 64, pass=1
      log_q.delete();
      start_job(100, 1);
      send(64, 32'h1000_0000);
      ivalid = 1'b1;
      idata  = 32'h1000_0040;
      repeat (3) tick();
      wait_idle();
      ivalid = 1'b0;
      tick();
      chk("clamp_count", log_q.size(), 64);
      chk("clamp_ie62", log_q[62].ie, 0);
      chk("clamp_ie63", log_q[63].ie, 1);
      chk("clamp_ae63", log_q[63].ae, 1);

      // Start/cfg while busy, then start in the o_done cycle
      log_q.delete();
      d0 = done_cnt;
      start_job(4, 2);
      send(3, 32'h2000_0000);
      start_job(1, 1);
      send(5, 32'h2000_0003);
      cfg_len  = 7'd1;
      cfg_pass = 9'd1;
      start    = 1'b1;
      @(negedge clk);
      done_seen = o_done;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("busy_done_cycle", done_seen, 1);
      chk("busy_after_late_start", o_busy, 0);
      chk("busy_count", log_q.size(), 8);
      chk("busy_ie0", log_q[0].ie, 0);
      chk("busy_ie3", log_q[3].ie, 1);
      chk("busy_ae3", log_q[3].ae, 0);
      chk("busy_ae7", log_q[7].ae, 1);
      chk("busy_done", done_cnt - d0, 1);

      // Reset mid-job after 5 of 8 beats
      d0 = done_cnt;
      start_job(8, 1);
      send(5, 32'h3000_0000);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_busy", o_busy, 0);
      log_q.delete();
      start_job(2, 1);
      send(2, 32'h3100_0000);
      wait_idle();
      chk("rst_next_count", log_q.size(), 2);
      chk("rst_next_ie0", log_q[0].ie, 0);
      chk("rst_next_ae1", log_q[1].ae, 1);
      chk("rst_next_done", done_cnt - d0, 1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
